// File: rtl/cpu_seq.sv
// Multi-cycle control sequencer: fetch, latch, execute, optional data-bus access, writeback,
// with halt support and a sticky trap state for illegal ops, bus timeouts and misaligned targets.
module cpu_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  output logic [31:0] ir_o,
  input  logic        illegal_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        is_jump_i,
  input  logic        is_branch_i,
  input  logic        wr_en_i,
  input  logic        branch_taken_i,
  input  logic [31:0] target_i,
  output logic        rf_wr_en_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  input  logic        bus_ack_i,
  output logic        ld_capture_o,
  input  logic        halt_req_i,
  output logic        halted_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o,
  output logic [31:0] instret_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LATCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_TRAP  = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b11;
  // Wait counter value seen during the TIMEOUT-th ack-less MEM cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] instret_q;
  logic [7:0]  wait_q;
  logic [1:0]  cause_q;

  logic mem_op;
  logic taken;
  logic misalign;
  logic expired;

  assign mem_op   = is_load_i | is_store_i;
  assign taken    = is_jump_i | (is_branch_i & branch_taken_i);
  assign misalign = taken & (target_i[1:0] != 2'b00);
  assign expired  = (wait_q == WAIT_LAST);

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (illegal_i)   state_d = ST_TRAP;
        else if (mem_op) state_d = ST_MEM;
        else             state_d = ST_WB;
      end
      // An ack in the expiry cycle takes priority over the timeout.
      ST_MEM: begin
        if (bus_ack_i)    state_d = ST_WB;
        else if (expired) state_d = ST_TRAP;
      end
      ST_WB: begin
        if (misalign)        state_d = ST_TRAP;
        else if (halt_req_i) state_d = ST_HALT;
        else                 state_d = ST_FETCH;
      end
      ST_HALT: if (!halt_req_i) state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    rf_wr_en_o   = 1'b0;
    bus_req_o    = 1'b0;
    bus_we_o     = 1'b0;
    ld_capture_o = 1'b0;
    halted_o     = 1'b0;
    trap_o       = 1'b0;
    case (state_q)
      ST_MEM: begin
        bus_req_o    = 1'b1;
        bus_we_o     = is_store_i;
        ld_capture_o = bus_ack_i & is_load_i;
      end
      ST_WB:   rf_wr_en_o = wr_en_i & ~is_store_i & ~misalign;
      ST_HALT: halted_o   = 1'b1;
      ST_TRAP: trap_o     = 1'b1;
      default: ;
    endcase
  end

  // Architectural registers, bus wait counter and trap cause
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      instret_q <= 32'h0;
      wait_q    <= 8'h0;
      cause_q   <= 2'b00;
    end else begin
      case (state_q)
        ST_LATCH: ir_q <= instr_i;
        ST_EXEC: begin
          wait_q <= 8'h0;
          if (illegal_i) cause_q <= CAUSE_ILLEGAL;
        end
        ST_MEM: begin
          if (!bus_ack_i) begin
            wait_q <= wait_q + 8'd1;
            if (expired) cause_q <= CAUSE_TIMEOUT;
          end
        end
        ST_WB: begin
          if (misalign) begin
            cause_q <= CAUSE_MISALIGN;
          end else begin
            pc_q      <= taken ? target_i : pc_q + 32'd4;
            instret_q <= instret_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_o         = pc_q;
  assign ir_o         = ir_q;
  assign instret_o    = instret_q;
  assign trap_cause_o = cause_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Bench for cpu_seq: ISA-level reference model predicts one record per instruction
// (fetch pc, length, writes, bus cycles, trap cause); a monitor rebuilds records from the pins.
module tb_cpu_seq;
  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          K_MAX    = 40;

  logic        clk_i, rstn_i;
  logic [31:0] pc_o, instr_i, ir_o, target_i, instret_o;
  logic        illegal_i, is_load_i, is_store_i, is_jump_i, is_branch_i, wr_en_i, branch_taken_i;
  logic        rf_wr_en_o, bus_req_o, bus_we_o, bus_ack_i, ld_capture_o;
  logic        halt_req_i, halted_o, trap_o;
  logic [1:0]  trap_cause_o;
  logic [2:0]  state_o;

  cpu_seq #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .pc_o(pc_o), .instr_i(instr_i), .ir_o(ir_o),
    .illegal_i(illegal_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .is_jump_i(is_jump_i), .is_branch_i(is_branch_i), .wr_en_i(wr_en_i),
    .branch_taken_i(branch_taken_i), .target_i(target_i), .rf_wr_en_o(rf_wr_en_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_ack_i(bus_ack_i),
    .ld_capture_o(ld_capture_o), .halt_req_i(halt_req_i), .halted_o(halted_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o), .instret_o(instret_o), .state_o(state_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  len;
    logic [7:0]  wr;
    logic [7:0]  busc;
    logic        we;
    logic [7:0]  cap;
    logic [1:0]  cause;
    logic [31:0] instret;
    logic        hlt;
  } rec_t;

  rec_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] prog [0:1023];
  int          plan_ack  [0:63];
  bit          plan_halt [0:63];
  int          plan_hdur [0:63];

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instruction encoding: [2:0] op (0/6 alu, 1 alu no-write, 2 load, 3 store, 4 jump,
  // 5 branch, 7 illegal), [3] branch taken, [4] jump writes link, [19:8] target byte address.
  function automatic logic [31:0] mk(input int op, input bit tk, input bit wb, input int tgt);
    logic [11:0] t;
    t = 12'(tgt);
    return {12'h0, t, 3'b000, wb, tk, 3'(op)};
  endfunction

  always_comb begin
    illegal_i      = (ir_o[2:0] == 3'd7);
    is_load_i      = (ir_o[2:0] == 3'd2);
    is_store_i     = (ir_o[2:0] == 3'd3);
    is_jump_i      = (ir_o[2:0] == 3'd4);
    is_branch_i    = (ir_o[2:0] == 3'd5);
    branch_taken_i = ir_o[3];
    wr_en_i        = (ir_o[2:0] inside {3'd0, 3'd2, 3'd3, 3'd6, 3'd7}) ||
                     (ir_o[2:0] == 3'd4 && ir_o[4]);
    target_i       = {20'h0, ir_o[19:8]};
  end

  // Synchronous instruction memory: data for the address seen one cycle earlier.
  logic [9:0] last_addr = '0;
  always @(negedge clk_i) begin
    instr_i   = prog[last_addr];
    last_addr = pc_o[11:2];
  end

  // Bus and halt driver, steered by the plan of the instruction in flight.
  int       mcnt = 0;
  int       hcnt = 0;
  logic [5:0] idx;
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      bus_ack_i  = 1'b0;
      halt_req_i = 1'b0;
      mcnt = 0;
      hcnt = 0;
    end else begin
      idx = instret_o[5:0];
      if (bus_req_o) begin
        mcnt++;
        bus_ack_i = (plan_ack[idx] == mcnt);
      end else begin
        mcnt = 0;
        bus_ack_i = 1'b0;
      end
      if (halted_o) begin
        hcnt++;
        if (hcnt >= plan_hdur[idx - 6'd1]) halt_req_i = 1'b0;
      end else begin
        hcnt = 0;
        // Non-halting instructions toggle halt_req during MEM only; it must be ignored there.
        halt_req_i = plan_halt[idx] ? 1'b1 : (bus_req_o && $urandom_range(0, 1) == 1);
      end
    end
  end

  // Monitor: assemble one record per instruction and compare against the scoreboard.
  bit          in_rec = 0;
  rec_t        cur;
  rec_t        exp_r;
  logic [31:0] last_inst = '0;
  always begin
    @(negedge clk_i);
    #2;
    if (!rstn_i) begin
      in_rec    = 0;
      last_inst = '0;
    end else begin
      if (in_rec && (instret_o != last_inst || trap_o)) begin
        cur.cause   = trap_o ? trap_cause_o : 2'b00;
        cur.instret = instret_o;
        cur.hlt     = halted_o;
        checks++;
        if (bus_req_o !== 1'b0 || rf_wr_en_o !== 1'b0) begin
          errors++;
          $display("FAIL quiet_after pc=%h: bus_req=%b rf_wr=%b, expected 0 0", cur.pc, bus_req_o, rf_wr_en_o);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_instr pc=%h: retired/trapped with no expectation", cur.pc);
        end else begin
          exp_r = exp_q.pop_front();
          if (cur !== exp_r) begin
            errors++;
            $display("FAIL record got pc=%h len=%0d wr=%0d busc=%0d we=%0d cap=%0d cause=%0d instret=%0d hlt=%0d, expected pc=%h len=%0d wr=%0d busc=%0d we=%0d cap=%0d cause=%0d instret=%0d hlt=%0d",
                     cur.pc, cur.len, cur.wr, cur.busc, cur.we, cur.cap, cur.cause, cur.instret, cur.hlt,
                     exp_r.pc, exp_r.len, exp_r.wr, exp_r.busc, exp_r.we, exp_r.cap, exp_r.cause, exp_r.instret, exp_r.hlt);
          end
        end
        in_rec = 0;
      end
      if (!in_rec && !halted_o && !trap_o) begin
        in_rec = 1;
        cur    = '0;
        cur.pc = pc_o;
      end
      if (in_rec) begin
        cur.len = cur.len + 8'd1;
        if (rf_wr_en_o)   cur.wr   = cur.wr + 8'd1;
        if (bus_req_o)    cur.busc = cur.busc + 8'd1;
        if (bus_req_o && bus_we_o) cur.we = 1'b1;
        if (ld_capture_o) cur.cap  = cur.cap + 8'd1;
      end
      last_inst = instret_o;
    end
  end

  // Reference model: walk the program at instruction granularity.
  task automatic build_expect(input int k_max, output bit trapped, output logic [1:0] cause,
                              output logic [31:0] fpc, output logic [31:0] finst);
    logic [31:0] pc, inst, w, tgt;
    int          op;
    bit          tk;
    rec_t        r;
    pc = RESET_PC; inst = 0; trapped = 0; cause = 2'b00;
    for (int k = 0; k < k_max; k++) begin
      w = prog[pc[11:2]];
      op = int'(w[2:0]);
      r = '0;
      r.pc = pc;
      r.instret = inst;
      if (op == 7) begin
        r.len = 8'd3; r.cause = 2'b01;
        exp_q.push_back(r); trapped = 1; cause = 2'b01; break;
      end
      if (op == 2 || op == 3) begin
        r.we = (op == 3);
        if (plan_ack[k] == 0) begin
          r.busc = 8'(TIMEOUT); r.len = 8'(3 + TIMEOUT); r.cause = 2'b10;
          exp_q.push_back(r); trapped = 1; cause = 2'b10; break;
        end
        r.busc = 8'(plan_ack[k]);
        r.cap  = (op == 2) ? 8'd1 : 8'd0;
      end
      r.len = 8'd4 + r.busc;
      tk  = (op == 4) || (op == 5 && w[3]);
      tgt = {20'h0, w[19:8]};
      if (tk && tgt[1:0] != 2'b00) begin
        r.cause = 2'b11;
        exp_q.push_back(r); trapped = 1; cause = 2'b11; break;
      end
      r.wr = ((op == 0 || op == 6 || op == 2) || (op == 4 && w[4])) ? 8'd1 : 8'd0;
      pc   = tk ? tgt : pc + 32'd4;
      inst = inst + 32'd1;
      r.instret = inst;
      r.hlt = plan_halt[k];
      exp_q.push_back(r);
    end
    fpc = pc; finst = inst;
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({pc_o, ir_o, instret_o, trap_o, trap_cause_o, halted_o, rf_wr_en_o, bus_req_o, bus_we_o, ld_capture_o}
        !== {RESET_PC, 32'h0, 32'h0, 8'h00}) begin
      errors++;
      $display("FAIL %s got pc=%h ir=%h instret=%0d trap=%b cause=%b halted=%b rf_wr=%b req=%b we=%b cap=%b, expected pc=%h and all others 0",
               name, pc_o, ir_o, instret_o, trap_o, trap_cause_o, halted_o, rf_wr_en_o, bus_req_o, bus_we_o, ld_capture_o, RESET_PC);
    end
  endtask

  task automatic hold_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    check_reset_values("reset_values");
    exp_q.delete();
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = mk(0, 0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      plan_ack[i] = 1; plan_halt[i] = 0; plan_hdur[i] = 1;
    end
  endtask

  task automatic rand_prog();
    int r, tgt;
    for (int i = 0; i < 1024; i++) begin
      r   = $urandom_range(0, 31);
      tgt = $urandom_range(0, 1023) * 4;
      if ($urandom_range(0, 15) == 0) tgt = tgt + $urandom_range(1, 3);
      prog[i] = mk((r == 0) ? 7 : (r < 8) ? 2 : (r < 12) ? 3 : (r < 15) ? 4 :
                   (r < 20) ? 5 : (r < 24) ? 1 : (r < 28) ? 6 : 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, tgt);
    end
    for (int i = 0; i < 64; i++) begin
      plan_ack[i]  = ($urandom_range(0, 12) == 0) ? 0 : $urandom_range(1, TIMEOUT);
      plan_halt[i] = ($urandom_range(0, 5) == 0);
      plan_hdur[i] = $urandom_range(1, 3);
    end
  endtask

  // Run a prepared program from reset until every expected record has been seen.
  task automatic run_episode(input int k_max);
    bit          trapped;
    logic [1:0]  cause;
    logic [31:0] fpc, finst;
    int          cyc;
    build_expect(k_max, trapped, cause, fpc, finst);
    release_reset();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk_i); #3; cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL episode_timeout: %0d records outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    if (trapped) begin
      repeat (3) @(negedge clk_i);
      #3;
      checks++;
      if (trap_o !== 1'b1 || trap_cause_o !== cause || bus_req_o !== 1'b0 || rf_wr_en_o !== 1'b0 ||
          pc_o !== fpc || instret_o !== finst || halted_o !== 1'b0) begin
        errors++;
        $display("FAIL trap_hold got trap=%b cause=%b req=%b rf_wr=%b pc=%h instret=%0d halted=%b, expected 1 %b 0 0 %h %0d 0",
                 trap_o, trap_cause_o, bus_req_o, rf_wr_en_o, pc_o, instret_o, halted_o, cause, fpc, finst);
      end
    end
  endtask

  initial begin
    rstn_i = 1'b0; bus_ack_i = 1'b0; halt_req_i = 1'b0;
    clear_prog();
    repeat (2) @(negedge clk_i);

    // Directed walk: three ALU ops, load/store, halt, taken/untaken branch, ack on last cycle, misaligned jump
    hold_reset();
    clear_prog();
    prog[0]  = mk(0, 0, 0, 0);
    prog[1]  = mk(0, 0, 0, 0);
    prog[2]  = mk(1, 0, 0, 0);
    prog[3]  = mk(2, 0, 0, 0);     plan_ack[3] = 3;
    prog[4]  = mk(3, 0, 0, 0);     plan_ack[4] = 1; plan_halt[4] = 1; plan_hdur[4] = 2;
    prog[5]  = mk(5, 1, 0, 'h100);
    prog[64] = mk(5, 0, 0, 'h200);
    prog[65] = mk(2, 0, 0, 0);     plan_ack[7] = TIMEOUT; plan_halt[7] = 1; plan_hdur[7] = 3;
    prog[66] = mk(4, 0, 1, 'h102);
    run_episode(K_MAX);

    // Illegal instruction at the reset vector
    hold_reset();
    clear_prog();
    prog[0] = mk(7, 0, 0, 0);
    run_episode(K_MAX);

    // Load with no acknowledge: bus timeout
    hold_reset();
    clear_prog();
    prog[0] = mk(2, 0, 0, 0); plan_ack[0] = 0;
    run_episode(K_MAX);

    // Reset in the middle of a store access
    hold_reset();
    clear_prog();
    prog[0] = mk(3, 0, 0, 0); plan_ack[0] = 0;
    begin
      bit          tr;
      logic [1:0]  ca;
      logic [31:0] fp, fi;
      int          cyc;
      build_expect(1, tr, ca, fp, fi);
      release_reset();
      cyc = 0;
      while (bus_req_o !== 1'b1 && cyc < 50) begin
        @(negedge clk_i); #1; cyc++;
      end
      checks++;
      if (bus_req_o !== 1'b1) begin
        errors++;
        $display("FAIL mem_entry: bus_req=%b after %0d cycles, expected 1", bus_req_o, cyc);
      end
      @(negedge clk_i);
      #1 rstn_i = 1'b0;
      #1;
      checks++;
      if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0) begin
        errors++;
        $display("FAIL async_reset_bus: req=%b we=%b, expected 0 0", bus_req_o, bus_we_o);
      end
      check_reset_values("mid_mem_reset");
      exp_q.delete();
    end

    // Randomized programs, ack delays and halt requests
    for (int e = 0; e < 30; e++) begin
      hold_reset();
      rand_prog();
      run_episode(K_MAX);
    end

    hold_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; SHALL be word-aligned.
REQ-002 Parameter TIMEOUT, default 16: maximum bus wait cycles per access; legal range 1..255.
REQ-003 clk_i  in  1  clock; all state updates on its rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 pc_o  out  32  fetch address to synchronous instruction memory (1-cycle read latency).
REQ-006 instr_i  in  32  instruction word; valid the cycle after pc_o is presented.
REQ-007 ir_o  out  32  latched instruction register driving the decoder.
REQ-008 illegal_i, is_load_i, is_store_i, is_jump_i, is_branch_i, wr_en_i  in  1 each  decoder outputs, combinational from ir_o.
REQ-009 branch_taken_i  in  1  ALU compare result for the current branch.
REQ-010 target_i  in  32  jump/branch target address.
REQ-011 rf_wr_en_o  out  1  register-file write strobe.
REQ-012 bus_req_o, bus_we_o  out  1 each  data bus request / write qualifier.
REQ-013 bus_ack_i  in  1  data bus acknowledge.
REQ-014 ld_capture_o  out  1  pulse telling the datapath to latch load data.
REQ-015 halt_req_i  in  1  halt request (sleep/debug); halted_o  out  1  core halted.
REQ-016 trap_o  out  1  sticky trap flag; trap_cause_o  out  2  01 illegal, 10 bus timeout, 11 misaligned target.
REQ-017 instret_o  out  32  retired-instruction counter.

Function
REQ-018 The FSM SHALL have states FETCH, LATCH, EXEC, MEM, WB, HALT, TRAP.
REQ-019 FETCH: pc_o = pc register; next state LATCH.
REQ-020 LATCH: ir_o <= instr_i; next state EXEC.
REQ-021 EXEC: illegal_i -> TRAP (cause 01); else is_load_i|is_store_i -> MEM; else -> WB.
REQ-022 MEM: bus_req_o=1, bus_we_o=is_store_i, both held stable until the ack cycle inclusive; on bus_ack_i -> WB; ld_capture_o=1 in the ack cycle iff is_load_i.
REQ-023 MEM wait counter SHALL reset on MEM entry, increment each cycle without ack; after TIMEOUT ack-less cycles -> TRAP (cause 10), bus_req_o deasserted the following cycle.
REQ-024 An ack arriving in the same cycle as counter expiry SHALL win (no trap).
REQ-025 WB: rf_wr_en_o=1 for exactly one cycle iff wr_en_i & ~is_store_i; instret_o increments by 1 (wraps 32'hFFFF_FFFF -> 0).
REQ-026 WB PC update: is_jump_i | (is_branch_i & branch_taken_i) -> pc <= target_i; else pc <= pc+4 (mod 2^32).
REQ-027 A taken jump/branch with target_i[1:0] != 0 SHALL go to TRAP (cause 11) instead of FETCH, with pc, rf_wr_en_o and instret_o unchanged.
REQ-028 WB exit: halt_req_i=1 -> HALT, else -> FETCH; halt_req_i is sampled only in WB, so an in-flight instruction always completes.
REQ-029 HALT: halted_o=1; on halt_req_i=0 -> FETCH next cycle with the updated pc.
REQ-030 TRAP: terminal until reset; trap_o=1, trap_cause_o held, no bus requests, no register writes, pc frozen.
REQ-031 Latency: ALU op 4 cycles (FETCH,LATCH,EXEC,WB); load/store 4+N cycles, N>=1 = MEM cycles up to and including ack.
REQ-032 rf_wr_en_o, bus_req_o and ld_capture_o SHALL be 0 in all states other than those stated above.

Reset
REQ-033 Asserting rstn_i SHALL immediately set state=FETCH, pc=RESET_PC, ir_o=0, instret_o=0, trap_o=0, trap_cause_o=0, halted_o=0, rf_wr_en_o=0, bus_req_o=0, bus_we_o=0, ld_capture_o=0, wait counter=0.
REQ-034 Reset mid-MEM SHALL drop bus_req_o asynchronously; the first fetch after deassertion is at RESET_PC.

Verification
REQ-035 Three ALU ops from 0x0 -> pc_o 0x0,0x4,0x8 at 4-cycle spacing; rf_wr_en_o one cycle each; instret_o=3.
REQ-036 Load, ack on 3rd MEM cycle -> bus_req_o high 3 cycles, ld_capture_o on the ack cycle, rf_wr_en_o in the next cycle; store with ack -> no rf_wr_en_o.
REQ-037 Load, no ack, TIMEOUT=4 -> TRAP after 4 MEM cycles, trap_cause_o=10, bus_req_o low; ack on the 4th cycle instead -> no trap.
REQ-038 Taken branch target 0x100 -> next pc_o=0x100; target 0x102 -> trap_cause_o=11, instret_o unchanged; untaken branch -> pc+4.
REQ-039 halt_req_i raised during MEM -> instruction retires, halted_o=1, no fetch; released -> fetch resumes at the next pc.
REQ-040 illegal_i in EXEC -> trap_cause_o=01 sticky; rstn_i pulse -> all outputs at reset values, fetch at RESET_PC.
